// File: rtl/mm_pkg.sv
// Shared types and helpers for the 2x2 matrix-multiply scheduler:
// element width, FSM state encoding, and packed-word <-> matrix conversion.
package mm_pkg;

    localparam int ELEM_W = 8;
    localparam int MAT_W  = 4 * ELEM_W;
    // Two products plus their sum fit in 2*ELEM_W+1 bits without loss.
    localparam int ACC_W  = 2 * ELEM_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL0 = 2'd1,
        COL1 = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef logic [ELEM_W-1:0] elem_t;

    // Field order matches the packed word: m00 sits in the MSBs.
    typedef struct packed {
        elem_t m00;
        elem_t m01;
        elem_t m10;
        elem_t m11;
    } mat_t;

    function automatic mat_t unpack_mat(input logic [MAT_W-1:0] w);
        mat_t m;
        m.m00 = w[MAT_W-1          -: ELEM_W];
        m.m01 = w[MAT_W-1-ELEM_W   -: ELEM_W];
        m.m10 = w[MAT_W-1-2*ELEM_W -: ELEM_W];
        m.m11 = w[MAT_W-1-3*ELEM_W -: ELEM_W];
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] pack_mat(input mat_t m);
        return {m.m00, m.m01, m.m10, m.m11};
    endfunction

endpackage

// File: rtl/mm2x2_scheduler_if.sv
// Bundle of the two requester channels, the result channel and busy.
// slave = scheduler side, master = producers/consumer side.
interface mm2x2_scheduler_if;
    import mm_pkg::*;

    logic             req0_valid;
    logic [MAT_W-1:0] req0_a;
    logic [MAT_W-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [MAT_W-1:0] req1_a;
    logic [MAT_W-1:0] req1_b;
    logic             req1_ready;

    logic             res_valid;
    logic             res_ready;
    logic [MAT_W-1:0] res_data;
    logic             res_id;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_data, res_id,
        input  res_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_data, res_id,
        output res_ready,
        input  busy
    );

endinterface

// File: rtl/mm2x2_col_mac.sv
// One column of a 2x2 product: given A and a column of B, returns the two
// result elements of that column, truncated to ELEM_W. Purely combinational.
module mm2x2_col_mac
    import mm_pkg::*;
(
    input  mat_t  a,
    input  elem_t b_top,
    input  elem_t b_bot,
    output elem_t c_top,
    output elem_t c_bot
);

    logic [ACC_W-1:0] sum_top;
    logic [ACC_W-1:0] sum_bot;

    // Row-by-column dot products at full width, then keep the low element bits.
    always_comb begin
        sum_top = ACC_W'(a.m00) * ACC_W'(b_top) + ACC_W'(a.m01) * ACC_W'(b_bot);
        sum_bot = ACC_W'(a.m10) * ACC_W'(b_top) + ACC_W'(a.m11) * ACC_W'(b_bot);
    end

    assign c_top = sum_top[ELEM_W-1:0];
    assign c_bot = sum_bot[ELEM_W-1:0];

endmodule

// File: rtl/mm2x2_scheduler.sv
// Round-robin scheduler sharing one 2x2 multiply datapath between two
// requesters. Captures an operand pair, computes column 0 then column 1,
// and holds the packed product until the consumer takes it.
module mm2x2_scheduler
    import mm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mm2x2_scheduler_if.slave bus
);

    state_t state_q, state_d;
    mat_t   a_q,     a_d;
    mat_t   b_q,     b_d;
    mat_t   res_q,   res_d;
    logic   id_q,    id_d;
    // Id of the requester served last; the other one wins a tie.
    logic   last_id_q, last_id_d;

    logic   gnt0;
    logic   gnt1;
    elem_t  b_top;
    elem_t  b_bot;
    elem_t  c_top;
    elem_t  c_bot;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt0 = bus.req0_valid && (!bus.req1_valid || last_id_q);
        gnt1 = bus.req1_valid && (!bus.req0_valid || !last_id_q);
    end

    // Feed the shared column MAC with B column 0 in COL0 and column 1 in COL1.
    always_comb begin
        b_top = b_q.m00;
        b_bot = b_q.m10;
        if (state_q == COL1) begin
            b_top = b_q.m01;
            b_bot = b_q.m11;
        end
    end

    mm2x2_col_mac u_col_mac (
        .a     (a_q),
        .b_top (b_top),
        .b_bot (b_bot),
        .c_top (c_top),
        .c_bot (c_bot)
    );

    // FSM next-state, capture and result-register updates, ready outputs.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        res_d          = res_q;
        id_d           = id_q;
        last_id_d      = last_id_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req0_ready = gnt0;
                bus.req1_ready = gnt1;
                if (gnt0 || gnt1) begin
                    a_d     = unpack_mat(gnt1 ? bus.req1_a : bus.req0_a);
                    b_d     = unpack_mat(gnt1 ? bus.req1_b : bus.req0_b);
                    id_d    = gnt1;
                    state_d = COL0;
                end
            end
            COL0: begin
                res_d.m00 = c_top;
                res_d.m10 = c_bot;
                state_d   = COL1;
            end
            COL1: begin
                res_d.m01 = c_top;
                res_d.m11 = c_bot;
                state_d   = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    last_id_d = id_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                // Unreachable encoding: recover to IDLE with a clean result.
                res_d   = '0;
                id_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;  // "last served = 1" gives requester 0 first priority
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
        end
    end

    assign bus.res_valid = (state_q == HOLD);
    assign bus.res_data  = pack_mat(res_q);
    assign bus.res_id    = id_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
